pc_fetch_sequencer: RTL and testbench

//  Sequences the program counter register and the instruction-memory fetch handshake.

---
 rtl/pc_fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer and single-outstanding instruction fetch with a one-entry decode buffer.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets vector to TRAP_VECTOR instead of being aligned down.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] fetch_count,
    output logic        misalign_trap,
    output logic [1:0]  dbg_state
);
    // Handshake: imem_req stays high with a stable imem_addr until the cycle imem_ack is seen;
    // instr_out is taken by decode in any HOLD cycle with decode_ready=1, stall=0 and no redirect.
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_trap_q, pend_trap_d;
    logic        req_gap_q, req_gap_d;
    logic        instr_valid_d;
    logic [31:0] instr_out_d, instr_pc_d, fetch_count_d;
    logic        trap_now;

    logic        redirect;
    logic [31:0] raw_target, redir_target;
    logic        redir_trap;
    logic        unused_trap_vector;

    assign redirect   = jump | branch_taken;
    assign raw_target = jump ? jump_target : branch_target;

`ifdef MISALIGN_TRAP_EN
    assign redir_target       = (raw_target[1:0] != 2'b00) ? TRAP_VECTOR : raw_target;
    assign redir_trap         = redirect & (raw_target[1:0] != 2'b00);
    assign unused_trap_vector = 1'b0;
`else
    assign redir_target       = raw_target & ~32'h3;
    assign redir_trap         = 1'b0;
    assign unused_trap_vector = ^TRAP_VECTOR;
`endif

    assign imem_addr     = pc_current;
    assign misalign_trap = trap_now;
    assign dbg_state     = state_q;

    always_comb begin
        state_d       = state_q;
        next_pc       = pc_current;
        imem_req      = 1'b0;
        trap_now      = 1'b0;
        redir_pend_d  = redir_pend_q;
        pend_target_d = pend_target_q;
        pend_trap_d   = pend_trap_q;
        req_gap_d     = 1'b0;
        instr_valid_d = instr_valid;
        instr_out_d   = instr_out;
        instr_pc_d    = instr_pc;
        fetch_count_d = fetch_count;
        case (state_q)
            BOOT: begin
                next_pc = RESET_ADDR;
                state_d = FETCH;
            end
            FETCH: begin
                if (req_gap_q) begin
                    // PC already holds the previous target; a fresh redirect simply replaces it.
                    if (redirect) begin
                        next_pc  = redir_target;
                        trap_now = redir_trap;
                    end
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (redirect) begin
                            next_pc      = redir_target;
                            trap_now     = redir_trap;
                            redir_pend_d = 1'b0;
                            req_gap_d    = 1'b1;
                        end else if (redir_pend_q) begin
                            next_pc      = pend_target_q;
                            trap_now     = pend_trap_q;
                            redir_pend_d = 1'b0;
                            req_gap_d    = 1'b1;
                        end else begin
                            instr_out_d   = imem_rdata;
                            instr_pc_d    = pc_current;
                            instr_valid_d = 1'b1;
                            state_d       = HOLD;
                        end
                    end else if (redirect) begin
                        redir_pend_d  = 1'b1;
                        pend_target_d = redir_target;
                        pend_trap_d   = redir_trap;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    next_pc       = redir_target;
                    trap_now      = redir_trap;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (decode_ready && !stall) begin
                    next_pc       = pc_current + PC_STEP;
                    fetch_count_d = fetch_count + 32'd1;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
        if (reset) begin
            next_pc  = RESET_ADDR;
            imem_req = 1'b0;
            trap_now = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            redir_pend_q  <= 1'b0;
            pend_target_q <= 32'h0;
            pend_trap_q   <= 1'b0;
            req_gap_q     <= 1'b0;
            instr_valid   <= 1'b0;
            instr_out     <= 32'h0;
            instr_pc      <= 32'h0;
            fetch_count   <= 32'h0;
        end else begin
            state_q       <= state_d;
            redir_pend_q  <= redir_pend_d;
            pend_target_q <= pend_target_d;
            pend_trap_q   <= pend_trap_d;
            req_gap_q     <= req_gap_d;
            instr_valid   <= instr_valid_d;
            instr_out     <= instr_out_d;
            instr_pc      <= instr_pc_d;
            fetch_count   <= fetch_count_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; models the external PC register and instruction memory.
module tb_pc_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] fetch_count;
    logic        misalign_trap;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_sequencer dut (
        .clock(clock), .reset(reset), .pc_current(pc_reg), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .decode_ready(decode_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .fetch_count(fetch_count), .misalign_trap(misalign_trap), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // External PC register: boots to 0 and loads next_pc every edge.
    always_ff @(posedge clock) begin
        if (reset) pc_reg <= 32'h0;
        else       pc_reg <= next_pc;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, ack it `delay` cycles later.
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data, input int delay);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        repeat (delay) begin
            tick();
            check("addr_stable", imem_addr, exp_addr);
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic accept();
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; decode_ready = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        repeat (3) tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_trap", {31'b0, misalign_trap}, 32'd0);
        reset = 1'b0;

        // Sequential fetches 0,4,8 with counts 1,2,3.
        serve(32'h0, 32'hC0DE_0000, 1);
        check("f0_valid", {31'b0, instr_valid}, 32'd1);
        check("f0_instr", instr_out, 32'hC0DE_0000);
        check("f0_pc", instr_pc, 32'h0);
        check("f0_count", fetch_count, 32'd0);
        accept();
        check("f0_count_after", fetch_count, 32'd1);
        check("f0_valid_after", {31'b0, instr_valid}, 32'd0);
        serve(32'h4, 32'hC0DE_0001, 1);
        check("f1_pc", instr_pc, 32'h4);
        check("f1_instr", instr_out, 32'hC0DE_0001);
        accept();
        check("f1_count", fetch_count, 32'd2);
        serve(32'h8, 32'hC0DE_0002, 1);
        check("f2_pc", instr_pc, 32'h8);

        // Stall blocks accept for 5 cycles.
        stall = 1'b1; decode_ready = 1'b1;
        repeat (5) begin
            tick();
            check("stall_pc", pc_reg, 32'h8);
            check("stall_instr", instr_out, 32'hC0DE_0002);
            check("stall_count", fetch_count, 32'd2);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        decode_ready = 1'b0;
        check("f2_count", fetch_count, 32'd3);

        // Jump in HOLD together with decode_ready: redirect wins, no count.
        serve(32'hC, 32'hC0DE_0003, 1);
        jump = 1'b1; jump_target = 32'h100; decode_ready = 1'b1;
        #1;
        check("jump_next_pc", next_pc, 32'h100);
        check("jump_trap", {31'b0, misalign_trap}, 32'd0);
        tick();
        jump = 1'b0; decode_ready = 1'b0;
        check("jump_count", fetch_count, 32'd3);
        check("jump_valid", {31'b0, instr_valid}, 32'd0);
        serve(32'h100, 32'hC0DE_0004, 1);
        check("jump_instr_pc", instr_pc, 32'h100);
        accept();
        check("f4_count", fetch_count, 32'd4);

        // Branch while fetch of 0x104 is outstanding; ack 3 cycles later is discarded.
        check("br_req", {31'b0, imem_req}, 32'd1);
        check("br_addr", imem_addr, 32'h104);
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check("br_addr_hold", imem_addr, 32'h104);
        tick();
        tick();
        imem_rdata = 32'hDEAD_BEEF; imem_ack = 1'b1;
        #1;
        check("br_next_pc", next_pc, 32'h40);
        tick();
        imem_ack = 1'b0;
        check("br_gap_req", {31'b0, imem_req}, 32'd0);
        check("br_valid", {31'b0, instr_valid}, 32'd0);
        serve(32'h40, 32'hC0DE_0005, 1);
        check("br_instr", instr_out, 32'hC0DE_0005);
        check("br_instr_pc", instr_pc, 32'h40);

        // Jump beats branch in the same cycle.
        jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
        #1;
        check("prio_next_pc", next_pc, 32'h200);
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        serve(32'h200, 32'hC0DE_0006, 1);
        check("prio_instr_pc", instr_pc, 32'h200);

        // Reset during FETCH; late ack in BOOT is ignored.
        accept();
        check("rf_addr", imem_addr, 32'h204);
        reset = 1'b1;
        tick();
        check("rf_req", {31'b0, imem_req}, 32'd0);
        reset = 1'b0;
        imem_rdata = 32'hBAD0_BAD0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("rf_valid", {31'b0, instr_valid}, 32'd0);
        check("rf_instr", instr_out, 32'h0);
        serve(32'h0, 32'hC0DE_0007, 1);
        check("rf_instr_after", instr_out, 32'hC0DE_0007);
        check("rf_count", fetch_count, 32'd0);

        // PC wrap at the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        serve(32'hFFFF_FFFC, 32'hC0DE_0008, 1);
        decode_ready = 1'b1;
        #1;
        check("wrap_next_pc", next_pc, 32'h0);
        tick();
        decode_ready = 1'b0;
        check("wrap_count", fetch_count, 32'd1);
        serve(32'h0, 32'hC0DE_0009, 1);

        // Misaligned jump target.
        jump = 1'b1; jump_target = 32'h102;
        #1;
`ifdef MISALIGN_TRAP_EN
        check("mis_next_pc", next_pc, 32'h80);
        check("mis_trap", {31'b0, misalign_trap}, 32'd1);
`else
        check("mis_next_pc", next_pc, 32'h100);
        check("mis_trap", {31'b0, misalign_trap}, 32'd0);
`endif
        tick();
        jump = 1'b0;
        check("mis_trap_after", {31'b0, misalign_trap}, 32'd0);
`ifdef MISALIGN_TRAP_EN
        serve(32'h80, 32'hC0DE_000A, 1);
        check("mis_instr_pc", instr_pc, 32'h80);
`else
        serve(32'h100, 32'hC0DE_000A, 1);
        check("mis_instr_pc", instr_pc, 32'h100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
